frodo_mem_hub: RTL and testbench
================================

# frodo_mem_hub

Parametrised successor to the fixed two-bank data-RAM hookup in the accelerator top level. It sits between the Control engine and `NUM_BANKS` single-port views of the data RAMs (the unused port of each dual RAM). It adds a host-side burst load/unload path so a host can preload operands and read back results without the debug taps.

Arbitration is at command granularity: the engine owns the RAMs unless a host burst is in flight.

## Interface
Parameters:
- `NUM_BANKS`, 2, number of RAM banks; `BANK_W = max(1, $clog2(NUM_BANKS))`
- `ADDR_WIDTH`, 12, word address width; bank depth is 2^ADDR_WIDTH
- `DATA_WIDTH`, 64, word width
- `RD_LATENCY`, 1, RAM read latency in cycles (1..3)

Ports:
- `clk` in 1: single clock
- `rstn` in 1: reset, synchronous, active-low
- `cmd_valid` in 1 / `cmd_ready` out 1: host command handshake
- `cmd_write` in 1: 1 = host→RAM burst, 0 = RAM→host burst
- `cmd_bank` in BANK_W: target bank
- `cmd_addr` in ADDR_WIDTH: start word address
- `cmd_len` in ADDR_WIDTH: word count minus 1
- `wr_data` in DATA_WIDTH, `wr_valid` in 1, `wr_ready` out 1: host write stream
- `rd_data` out DATA_WIDTH, `rd_valid` out 1, `rd_ready` in 1: host read stream
- `done` out 1: one-cycle pulse at burst end
- `eng_req` in 1: engine wants the RAMs
- `eng_gnt` out 1: engine owns the RAMs
- `eng_addr` in NUM_BANKS*ADDR_WIDTH, `eng_we` in NUM_BANKS, `eng_wdata` in DATA_WIDTH: engine-side RAM port signals
- `ram_addr` out NUM_BANKS*ADDR_WIDTH, `ram_we` out NUM_BANKS, `ram_wdata` out DATA_WIDTH: to RAMs
- `ram_rdata` in NUM_BANKS*DATA_WIDTH: from RAMs, also routed directly to the engine
- `xfer_sum` out DATA_WIDTH: burst checksum (see Configuration)

## Operation
- FSM states: IDLE, WRITE, READ, DRAIN.
- `cmd_ready` = (state==IDLE) && !eng_req. An out-of-range `cmd_bank` (≥ NUM_BANKS) is accepted, and the burst completes with no RAM writes and all-zero read data.
- `eng_gnt` = (state==IDLE). While it is high, `ram_*` are the engine signals passed through combinationally. While it is low, engine signals are ignored and all `ram_we` bits outside the host write are 0.
- WRITE: `wr_ready` = 1. Each `wr_valid && wr_ready` registers address, data and a one-hot `ram_we` for the next cycle, then increments the address. After cmd_len+1 beats the FSM returns to IDLE and pulses `done`.
- READ: issue one read address per cycle while credits remain. Credits: outstanding + FIFO occupancy < RD_LATENCY+2, and the FIFO depth is RD_LATENCY+2. Returned words enter the FIFO. After the last address is issued the FSM enters DRAIN. When the last word leaves via `rd_valid && rd_ready`, the FSM returns to IDLE and pulses `done`.
- Address arithmetic is modulo 2^ADDR_WIDTH; a burst wraps within the bank (…FFF → 000).
- Beat counter is ADDR_WIDTH+1 bits; cmd_len = all-ones is a full-bank burst.
- `rd_data` holds its value while `rd_valid && !rd_ready` (no drop, no duplicate).

## Timing
- Reset values: state IDLE; `cmd_ready` = !eng_req; `eng_gnt` 1; `wr_ready` 0; `rd_valid` 0; `rd_data` 0; `done` 0; `xfer_sum` 0; FIFO empty; credits full.
- Write: beat accepted at T → RAM write at edge T+1. `done` is asserted on the cycle after the final write is presented.
- Read: command accepted at T → first address at T+1 → data at T+1+RD_LATENCY → `rd_valid` at T+2+RD_LATENCY. Without backpressure, throughput is 1 word/cycle.
- `eng_gnt` drops the cycle after accept and rises in the cycle `done` is high. `cmd_ready` is low that cycle.
- If `eng_req` and `cmd_valid` rise in the same cycle in IDLE, the engine wins: no accept.
- `rstn` low mid-burst: next edge forces IDLE, flushes the FIFO, and zeroes outputs. Partial writes already committed stay in RAM.

## Configuration
- `FRODO_HUB_CHECKSUM_EN` defined: `xfer_sum` is the XOR of every word written or delivered during the current burst. It clears on command accept and is stable from `done` until the next accept.
- Not defined: `xfer_sum` is tied to 0 and no checksum register is built.

## Test plan
- Write bank 1, addr 0x010, len 3, data 0x11..0x44 → `ram_we` = 2'b10 for 4 cycles at 0x010..0x013. Read back → 0x11,0x22,0x33,0x44, then `done`.
- Read len 7 with `rd_ready` toggling 1/0 → exactly 8 words, in order, no duplicates, FIFO never overflows.
- Write addr 0xFFE, len 3 → writes at 0xFFE, 0xFFF, 0x000, 0x001.
- `eng_req` = 1 with `cmd_valid` = 1 → `cmd_ready` = 0 and `eng_gnt` = 1 until `eng_req` falls. Engine writes pass through unchanged.
- `rstn` low at beat 2 of an 8-beat read → next cycle IDLE, `rd_valid` 0, `eng_gnt` 1. A new command then works.
- With macro defined: write 0x0F, 0xF0, 0xFF → `xfer_sum` = 0x00. Write 0x01, 0x02 → `xfer_sum` = 0x03.

Source files
------------

// File: rtl/frodo_mem_hub.sv
// frodo_mem_hub: arbitrates NUM_BANKS single-port data-RAM views between the
// Control engine and a host burst load/unload path.
// Optional feature macro: FRODO_HUB_CHECKSUM_EN builds the xfer_sum XOR register.

// Per-bank port mux: engine passthrough while granted, host side otherwise.
module frodo_mem_hub_bank #(
  parameter int AW = 12
) (
  input  logic          gnt,
  input  logic [AW-1:0] eng_addr,
  input  logic          eng_we,
  input  logic [AW-1:0] host_addr,
  input  logic          host_we,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we
);
  assign ram_addr = gnt ? eng_addr : host_addr;
  assign ram_we   = gnt ? eng_we   : host_we;
endmodule

module frodo_mem_hub #(
  parameter int NUM_BANKS  = 2,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64,
  parameter int RD_LATENCY = 1,
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_write,
  input  logic [BANK_W-1:0]                cmd_bank,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic [ADDR_WIDTH-1:0]            cmd_len,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_valid,
  input  logic                             rd_ready,
  output logic                             done,
  input  logic                             eng_req,
  output logic                             eng_gnt,
  input  logic [NUM_BANKS*ADDR_WIDTH-1:0]  eng_addr,
  input  logic [NUM_BANKS-1:0]             eng_we,
  input  logic [DATA_WIDTH-1:0]            eng_wdata,
  output logic [NUM_BANKS*ADDR_WIDTH-1:0]  ram_addr,
  output logic [NUM_BANKS-1:0]             ram_we,
  output logic [DATA_WIDTH-1:0]            ram_wdata,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]  ram_rdata,
  output logic [DATA_WIDTH-1:0]            xfer_sum
);
  localparam int AW    = ADDR_WIDTH;
  localparam int DW    = DATA_WIDTH;
  localparam int DEPTH = RD_LATENCY + 2;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t              state, nxt;
  logic                is_wr, done_q, accept, beat, issue, push, pop, last_pop;
  logic [BANK_W-1:0]   bank_q;
  logic [AW-1:0]       cur_addr, h_addr, host_addr;
  logic [AW:0]         beats_left;
  logic [NUM_BANKS-1:0] h_we, bank_oh;
  logic [DW-1:0]       h_wdata, rsel;
  logic [RD_LATENCY-1:0] vld_q;
  logic [RD_LATENCY:0] vld_pipe;   // vld_pipe[i]: a read was issued i cycles ago
  logic [CNT_W-1:0]    inflight, fcnt;
  logic [CNT_W:0]      occ;
  logic [DW-1:0]       fifo_mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;

  assign eng_gnt   = (state == IDLE);
  assign cmd_ready = (state == IDLE) && !eng_req && !done_q;
  assign accept    = cmd_valid && cmd_ready;
  assign wr_ready  = (state == WRITE);
  assign beat      = wr_valid && wr_ready;
  assign done      = done_q;
  assign rd_valid  = (fcnt != '0);
  assign rd_data   = rd_valid ? fifo_mem[rd_ptr] : '0;
  assign pop       = rd_valid && rd_ready;
  assign vld_pipe  = {vld_q, issue};
  assign push      = vld_pipe[RD_LATENCY];
  assign occ       = {1'b0, inflight} + {1'b0, fcnt};
  assign issue     = (state == READ) && (occ < (CNT_W+1)'(DEPTH));
  assign last_pop  = pop && (fcnt == CNT_W'(1)) && (vld_pipe[RD_LATENCY:1] == '0);
  assign host_addr = (state == READ) ? cur_addr : h_addr;
  assign ram_wdata = eng_gnt ? eng_wdata : h_wdata;

  // Reads in flight, bank decode and returned-word select for the target bank
  always_comb begin
    inflight = '0;
    for (int i = 1; i <= RD_LATENCY; i++) inflight = inflight + CNT_W'(vld_pipe[i]);
    bank_oh = '0;
    rsel    = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_q == BANK_W'(b)) begin
        bank_oh[b] = 1'b1;
        rsel       = ram_rdata[b*DW +: DW];
      end
    end
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (accept) nxt = cmd_write ? WRITE : READ;
      WRITE: if (beat && beats_left == (AW+1)'(1)) nxt = DRAIN;
      READ:  if (issue && beats_left == (AW+1)'(1)) nxt = DRAIN;
      DRAIN: if (is_wr || last_pop) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // FSM, burst bookkeeping, registered host write port and read FIFO control
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      done_q     <= 1'b0;
      is_wr      <= 1'b0;
      bank_q     <= '0;
      cur_addr   <= '0;
      beats_left <= '0;
      h_we       <= '0;
      h_addr     <= '0;
      h_wdata    <= '0;
      vld_q      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fcnt       <= '0;
    end else begin
      state  <= nxt;
      done_q <= (state == DRAIN) && (nxt == IDLE);
      h_we   <= '0;
      vld_q  <= vld_pipe[RD_LATENCY-1:0];
      if (accept) begin
        is_wr      <= cmd_write;
        bank_q     <= cmd_bank;
        cur_addr   <= cmd_addr;
        beats_left <= {1'b0, cmd_len} + (AW+1)'(1);
      end
      if (beat) begin
        h_addr  <= cur_addr;
        h_wdata <= wr_data;
        h_we    <= bank_oh;
      end
      if (beat || issue) begin
        cur_addr   <= cur_addr + AW'(1);
        beats_left <= beats_left - (AW+1)'(1);
      end
      if (push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fcnt <= fcnt + CNT_W'(1);
        2'b01:   fcnt <= fcnt - CNT_W'(1);
        default: fcnt <= fcnt;
      endcase
    end
  end

  // FIFO storage; contents are only visible while the count is non-zero
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= rsel;
  end

  genvar gb;
  generate
    for (gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
      frodo_mem_hub_bank #(.AW(AW)) u_bank (
        .gnt       (eng_gnt),
        .eng_addr  (eng_addr[gb*AW +: AW]),
        .eng_we    (eng_we[gb]),
        .host_addr (host_addr),
        .host_we   (h_we[gb]),
        .ram_addr  (ram_addr[gb*AW +: AW]),
        .ram_we    (ram_we[gb])
      );
    end
  endgenerate

`ifdef FRODO_HUB_CHECKSUM_EN
  logic [DW-1:0] sum_q;
  // XOR of every word written or delivered in the current burst
  always_ff @(posedge clk) begin
    if (!rstn)       sum_q <= '0;
    else if (accept) sum_q <= '0;
    else             sum_q <= sum_q ^ (beat ? wr_data : '0) ^ (pop ? rd_data : '0);
  end
  assign xfer_sum = sum_q;
`else
  assign xfer_sum = '0;
`endif

endmodule

// File: tb/tb_frodo_mem_hub.sv
// Directed bench for frodo_mem_hub with a 2-bank, 1-cycle-latency RAM model.
module tb_frodo_mem_hub;
  localparam int NB = 2, AW = 12, DW = 64;
`ifdef FRODO_HUB_CHECKSUM_EN
  localparam logic [DW-1:0] SUM_T1 = 64'h44, SUM_A = 64'h00, SUM_B = 64'h03;
`else
  localparam logic [DW-1:0] SUM_T1 = 64'h0, SUM_A = 64'h0, SUM_B = 64'h0;
`endif

  logic clk = 1'b0, rstn = 1'b0;
  logic cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [0:0] cmd_bank = '0;
  logic [AW-1:0] cmd_addr = '0, cmd_len = '0;
  logic [DW-1:0] wr_data = '0, rd_data, eng_wdata = '0, ram_wdata, xfer_sum;
  logic wr_valid = 0, wr_ready, rd_valid, rd_ready = 0, done, eng_req = 0, eng_gnt;
  logic [NB*AW-1:0] eng_addr = '0, ram_addr;
  logic [NB-1:0] eng_we = '0, ram_we;
  logic [NB*DW-1:0] ram_rdata;

  logic [DW-1:0] mem [NB][1<<AW];
  logic [DW-1:0] rq [NB];
  logic [DW-1:0] wdat [16];
  logic [DW-1:0] rexp [16];
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  frodo_mem_hub #(.NUM_BANKS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_bank(cmd_bank), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .done(done),
    .eng_req(eng_req), .eng_gnt(eng_gnt), .eng_addr(eng_addr), .eng_we(eng_we),
    .eng_wdata(eng_wdata), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .xfer_sum(xfer_sum)
  );

  // RAM model: synchronous write, registered read
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (ram_we[b]) mem[b][ram_addr[b*AW +: AW]] <= ram_wdata;
      rq[b] <= mem[b][ram_addr[b*AW +: AW]];
    end
  end
  assign ram_rdata = {rq[1], rq[0]};

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_burst(input int bank, input logic [AW-1:0] addr, input int len);
    logic [AW-1:0] ea;
    cmd_valid = 1; cmd_write = 1; cmd_bank = 1'(bank); cmd_addr = addr; cmd_len = AW'(len);
    #1 chk("wr_cmd_ready", cmd_ready, 1);
    tick;
    cmd_valid = 0;
    chk("wr_gnt_low", eng_gnt, 0);
    eng_we = 2'b11;  // engine activity must be ignored during the burst
    for (int i = 0; i <= len; i++) begin
      wr_valid = 1; wr_data = wdat[i];
      #1 chk("wr_ready", wr_ready, 1);
      tick;
      ea = addr + AW'(i);
      chk("wr_we", ram_we, (bank == 0) ? 2'b01 : 2'b10);
      chk("wr_addr", ram_addr[bank*AW +: AW], ea);
      chk("wr_wdata", ram_wdata, wdat[i]);
    end
    wr_valid = 0; eng_we = 2'b00;
    #1 chk("wr_ready_off", wr_ready, 0);
    chk("wr_done_early", done, 0);
    tick;
    chk("wr_done", done, 1);
    chk("wr_done_gnt", eng_gnt, 1);
    chk("wr_done_cmd_ready", cmd_ready, 0);
    tick;
    chk("wr_done_clr", done, 0);
    chk("wr_idle_cmd_ready", cmd_ready, 1);
  endtask

  task automatic rd_burst(input int bank, input logic [AW-1:0] addr, input int len, input bit toggle);
    int got = 0, cyc, first = -1, donec = -1;
    logic [DW-1:0] prev = '0;
    bit hold = 0;
    cmd_valid = 1; cmd_write = 0; cmd_bank = 1'(bank); cmd_addr = addr; cmd_len = AW'(len);
    #1 chk("rd_cmd_ready", cmd_ready, 1);
    tick;
    cmd_valid = 0; cyc = 1;
    chk("rd_first_addr", ram_addr[bank*AW +: AW], addr);
    while (donec < 0 && cyc < 200) begin
      rd_ready = toggle ? cyc[0] : 1'b1;
      #1;
      if (hold) chk("rd_hold", rd_data, prev);
      hold = rd_valid && !rd_ready;
      prev = rd_data;
      if (rd_valid && first < 0) first = cyc;
      if (rd_valid && rd_ready) begin
        if (got <= len) chk("rd_word", rd_data, rexp[got]);
        got++;
      end
      if (done) donec = cyc;
      tick;
      cyc++;
    end
    rd_ready = 0;
    chk("rd_count", got, len + 1);
    chk("rd_done_seen", donec >= 0, 1);
    if (!toggle) begin
      chk("rd_first_valid_cyc", first, 3);
      chk("rd_done_cyc", donec, 4 + len);
    end
    chk("rd_valid_after", rd_valid, 0);
  endtask

  initial begin
    int got, cyc;
    // reset state
    tick; tick;
    chk("rst_gnt", eng_gnt, 1);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", xfer_sum, 0);
    eng_req = 1;
    #1 chk("rst_cmd_ready_eng", cmd_ready, 0);
    eng_req = 0;
    rstn = 1;
    tick;

    // write bank 1 @0x010, then read it back
    wdat[0] = 64'h11; wdat[1] = 64'h22; wdat[2] = 64'h33; wdat[3] = 64'h44;
    wr_burst(1, 12'h010, 3);
    chk("t1_wr_sum", xfer_sum, SUM_T1);
    for (int i = 0; i < 4; i++) rexp[i] = wdat[i];
    rd_burst(1, 12'h010, 3, 0);
    chk("t1_rd_sum", xfer_sum, SUM_T1);

    // 8-word read with rd_ready toggling
    for (int i = 0; i < 8; i++) begin wdat[i] = 64'h100 + 64'(i); rexp[i] = wdat[i]; end
    wr_burst(0, 12'h020, 7);
    rd_burst(0, 12'h020, 7, 1);

    // wrap within bank
    wdat[0] = 64'hA1; wdat[1] = 64'hB2; wdat[2] = 64'hC3; wdat[3] = 64'hD4;
    wr_burst(0, 12'hFFE, 3);
    for (int i = 0; i < 4; i++) rexp[i] = wdat[i];
    rd_burst(0, 12'hFFE, 3, 0);
    chk("wrap_mem_000", mem[0][12'h000], 64'hC3);

    // engine wins over a simultaneous command; engine writes pass through
    eng_req = 1; cmd_valid = 1; cmd_write = 1; cmd_bank = 1'b0; cmd_addr = 12'h300; cmd_len = 12'h0;
    eng_we = 2'b01; eng_addr = {12'h0AA, 12'h055}; eng_wdata = 64'hDEAD_BEEF;
    #1 chk("eng_cmd_ready", cmd_ready, 0);
    chk("eng_gnt", eng_gnt, 1);
    chk("eng_ram_we", ram_we, 2'b01);
    chk("eng_ram_addr", ram_addr, {12'h0AA, 12'h055});
    chk("eng_ram_wdata", ram_wdata, 64'hDEAD_BEEF);
    tick;
    eng_we = 2'b00;
    #1 chk("eng_gnt_hold", eng_gnt, 1);
    chk("eng_cmd_ready_hold", cmd_ready, 0);
    chk("eng_mem_write", mem[0][12'h055], 64'hDEAD_BEEF);
    eng_req = 0; cmd_valid = 0;
    #1 chk("eng_release_cmd_ready", cmd_ready, 1);
    tick;

    // reset in the middle of an 8-beat read
    for (int i = 0; i < 8; i++) rexp[i] = 64'h100 + 64'(i);
    cmd_valid = 1; cmd_write = 0; cmd_bank = 1'b0; cmd_addr = 12'h020; cmd_len = 12'h007;
    rd_ready = 1;
    tick;
    cmd_valid = 0;
    got = 0; cyc = 0;
    while (got < 2 && cyc < 50) begin
      #1;
      if (rd_valid && rd_ready) got++;
      tick;
      cyc++;
    end
    chk("mrst_pre_beats", got, 2);
    rstn = 0;
    tick;
    chk("mrst_rd_valid", rd_valid, 0);
    chk("mrst_rd_data", rd_data, 0);
    chk("mrst_gnt", eng_gnt, 1);
    chk("mrst_done", done, 0);
    chk("mrst_cmd_ready", cmd_ready, 1);
    chk("mrst_sum", xfer_sum, 0);
    rstn = 1; rd_ready = 0;
    tick;
    rd_burst(0, 12'h020, 7, 0);

    // checksum bursts
    wdat[0] = 64'h0F; wdat[1] = 64'hF0; wdat[2] = 64'hFF;
    wr_burst(1, 12'h200, 2);
    chk("sum_a", xfer_sum, SUM_A);
    wdat[0] = 64'h01; wdat[1] = 64'h02;
    wr_burst(1, 12'h210, 1);
    chk("sum_b", xfer_sum, SUM_B);
    tick;
    chk("sum_b_stable", xfer_sum, SUM_B);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
